// File: rtl/sequence_generator_111000101011_errinj.sv
// Serial frame generator: PATTERN ^ latched error mask, MSB first, then GAP_CYCLES idle bit-times.
// Latency: first bit one cycle after i_start is sampled in IDLE; o_done pulses one cycle after the frame ends.
// Backpressure: none; i_start is ignored while busy, and i_repeat chains frames with no idle cycle.
module sequence_generator_111000101011_errinj #(
    parameter int               WIDTH      = 12,
    parameter logic [WIDTH-1:0] PATTERN    = 12'b111000101011,
    parameter int               GAP_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_err_mask,
    input  logic             i_repeat,
    output logic             o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_err_cnt,
    output logic [7:0]       o_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic last_bit;
    logic last_gap;
    logic end_of_frame;
    logic load;

    function automatic logic [3:0] popcount(input logic [WIDTH-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame boundary decode shared by the FSM and the datapath
    always_comb begin
        last_bit     = (state_q == SEND) && (bit_cnt_q == BIT_LAST);
        last_gap     = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
        end_of_frame = HAS_GAP ? last_gap : last_bit;
        load         = ((state_q == IDLE) && i_start) || (end_of_frame && i_repeat);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_bit) begin
                    if (HAS_GAP) begin
                        state_d = GAP;
                    end else begin
                        state_d = i_repeat ? SEND : DONE;
                    end
                end
            end
            GAP: begin
                if (last_gap) begin
                    state_d = i_repeat ? SEND : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: the frame shifts left so the MSB is always the bit on the wire
    always_comb begin
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = '0;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if (load) begin
            frame_d   = PATTERN ^ i_err_mask;
            err_cnt_d = popcount(i_err_mask);
            bit_cnt_d = '0;
        end else if (state_q == SEND) begin
            frame_d   = frame_q << 1;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end

        if ((state_q == GAP) && !last_gap) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
        end

        if (end_of_frame && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Outputs decode from registered state, so reset clears them without waiting for a clock
    always_comb begin
        o_valid     = (state_q == SEND);
        o_data      = (state_q == SEND) && frame_q[WIDTH-1];
        o_busy      = (state_q == SEND) || (state_q == GAP);
        o_done      = (state_q == DONE);
        o_err_cnt   = err_cnt_q;
        o_frame_cnt = frame_cnt_q;
    end

endmodule

// File: tb/tb_sequence_generator_111000101011_errinj.sv
// Directed bench: instance a uses the default 2-cycle gap, instance b runs with no gap for repeat mode.
module tb_sequence_generator_111000101011_errinj;

    localparam logic [11:0] PAT     = 12'b111000101011;
    localparam logic [11:0] ERR801  = 12'b011000101010;
    localparam logic [11:0] ERR007  = 12'b111000101100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_start, a_repeat;
    logic [11:0] a_mask;
    logic        a_data, a_valid, a_busy, a_done;
    logic [3:0]  a_err_cnt;
    logic [7:0]  a_frame_cnt;
    logic        b_start, b_repeat;
    logic [11:0] b_mask;
    logic        b_data, b_valid, b_busy, b_done;
    logic [3:0]  b_err_cnt;
    logic [7:0]  b_frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequence_generator_111000101011_errinj #(
        .WIDTH(12), .PATTERN(12'b111000101011), .GAP_CYCLES(2)
    ) dut_a (
        .i_clk(clk), .i_resetn(resetn), .i_start(a_start), .i_err_mask(a_mask),
        .i_repeat(a_repeat), .o_data(a_data), .o_valid(a_valid), .o_busy(a_busy),
        .o_done(a_done), .o_err_cnt(a_err_cnt), .o_frame_cnt(a_frame_cnt)
    );

    sequence_generator_111000101011_errinj #(
        .WIDTH(12), .PATTERN(12'b111000101011), .GAP_CYCLES(0)
    ) dut_b (
        .i_clk(clk), .i_resetn(resetn), .i_start(b_start), .i_err_mask(b_mask),
        .i_repeat(b_repeat), .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy),
        .o_done(b_done), .o_err_cnt(b_err_cnt), .o_frame_cnt(b_frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream detector model: matches when at most two bits differ from PATTERN
    function automatic logic tolerant_match(input logic [11:0] word);
        return ($countones(word ^ PAT) <= 2);
    endfunction

    task automatic capture_a(input logic [11:0] mask, output logic [11:0] bits,
                             output int nvalid, output int ngap, output int ndone,
                             output logic [3:0] errc);
        bits = '0; nvalid = 0; ngap = 0; ndone = 0; errc = '0;
        a_mask  = mask;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int t = 0; t < 40 && ndone == 0; t++) begin
            if (a_valid) begin
                if (nvalid == 0) errc = a_err_cnt;
                bits = {bits[10:0], a_data};
                nvalid++;
            end else if (a_busy) begin
                ngap++;
            end
            if (a_done) ndone++;
            step();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; a_start = 1'b0; a_repeat = 1'b0; a_mask = '0;
        b_start = 1'b0; b_repeat = 1'b0; b_mask = '0;
        #3;
        checks++;
        if ({a_data, a_valid, a_busy, a_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_a_flags got %b want 0000", {a_data, a_valid, a_busy, a_done});
        end
        checks++;
        if (a_err_cnt !== 4'd0 || a_frame_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_a_counts got err=%0d frames=%0d want 0 0", a_err_cnt, a_frame_cnt);
        end
        checks++;
        if ({b_data, b_valid, b_busy, b_done} !== 4'b0000 || b_frame_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_b got flags=%b frames=%0d want 0000 0", {b_data, b_valid, b_busy, b_done}, b_frame_cnt);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", a_busy, a_valid);
        end
    endtask

    task automatic test_clean();
        logic [11:0] exp_bits;
        exp_bits = PAT;
        a_mask  = '0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (a_valid !== 1'b1 || a_busy !== 1'b1 || a_data !== exp_bits[11-k]) begin
                errors++; $display("FAIL clean_bit%0d got v=%b b=%b d=%b want 1 1 %b", k, a_valid, a_busy, a_data, exp_bits[11-k]);
            end
            if (k == 0) begin
                checks++;
                if (a_err_cnt !== 4'd0) begin
                    errors++; $display("FAIL clean_err_cnt got %0d want 0", a_err_cnt);
                end
            end
            step();
        end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (a_valid !== 1'b0 || a_data !== 1'b0 || a_busy !== 1'b1 || a_done !== 1'b0) begin
                errors++; $display("FAIL clean_gap%0d got v=%b d=%b b=%b done=%b want 0 0 1 0", g, a_valid, a_data, a_busy, a_done);
            end
            step();
        end
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_frame_cnt !== 8'd1) begin
            errors++; $display("FAIL clean_done got done=%b busy=%b frames=%0d want 1 0 1", a_done, a_busy, a_frame_cnt);
        end
        step();
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL clean_idle got done=%b busy=%b want 0 0", a_done, a_busy);
        end
    endtask

    task automatic test_err_inject();
        logic [11:0] bits; int nv, ng, nd; logic [3:0] ec;
        capture_a(12'h801, bits, nv, ng, nd, ec);
        checks++;
        if (bits !== ERR801 || nv != 12) begin
            errors++; $display("FAIL err801_bits got %b (%0d valid) want %b (12)", bits, nv, ERR801);
        end
        checks++;
        if (ec !== 4'd2) begin
            errors++; $display("FAIL err801_cnt got %0d want 2", ec);
        end
        checks++;
        if (tolerant_match(bits) !== 1'b1) begin
            errors++; $display("FAIL err801_detect got %b want 1", tolerant_match(bits));
        end
        checks++;
        if (ng != 2 || nd != 1 || a_frame_cnt !== 8'd2) begin
            errors++; $display("FAIL err801_frame got gap=%0d done=%0d frames=%0d want 2 1 2", ng, nd, a_frame_cnt);
        end
    endtask

    task automatic test_over_tolerance();
        logic [11:0] bits; int nv, ng, nd; logic [3:0] ec;
        capture_a(12'h007, bits, nv, ng, nd, ec);
        checks++;
        if (bits !== ERR007 || bits[2:0] !== 3'b100) begin
            errors++; $display("FAIL err007_bits got %b want %b", bits, ERR007);
        end
        checks++;
        if (ec !== 4'd3) begin
            errors++; $display("FAIL err007_cnt got %0d want 3", ec);
        end
        checks++;
        if (tolerant_match(bits) !== 1'b0) begin
            errors++; $display("FAIL err007_detect got %b want 0", tolerant_match(bits));
        end
        checks++;
        if (a_frame_cnt !== 8'd3) begin
            errors++; $display("FAIL err007_frames got %0d want 3", a_frame_cnt);
        end
    endtask

    task automatic test_busy_ignore();
        logic [11:0] bits; int nv, nd;
        bits = '0; nv = 0; nd = 0;
        a_mask  = '0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (t == 3)  a_mask  = 12'hFFF;
            if (t == 5)  a_start = 1'b1;
            if (t == 6)  a_start = 1'b0;
            if (t == 12) a_start = 1'b1;
            if (t == 13) a_start = 1'b0;
            if (a_valid) begin
                bits = {bits[10:0], a_data};
                nv++;
            end
            if (a_done) nd++;
            step();
        end
        a_mask = '0;
        checks++;
        if (nv != 12 || nd != 1) begin
            errors++; $display("FAIL busy_ignore got valid=%0d done=%0d want 12 1", nv, nd);
        end
        checks++;
        if (bits !== PAT) begin
            errors++; $display("FAIL busy_mask_change got %b want %b", bits, PAT);
        end
        checks++;
        if (a_frame_cnt !== 8'd4 || a_busy !== 1'b0) begin
            errors++; $display("FAIL busy_frames got frames=%0d busy=%b want 4 0", a_frame_cnt, a_busy);
        end
    endtask

    task automatic test_repeat();
        logic [35:0] stream; int nv, v36, nd, done_at; logic [3:0] ec2; logic [7:0] cnt_done;
        stream = '0; nv = 0; v36 = 0; nd = 0; done_at = -1; ec2 = '0; cnt_done = '0;
        b_mask   = '0;
        b_repeat = 1'b1;
        b_start  = 1'b1;
        step();
        b_start = 1'b0;
        for (int t = 0; t < 45; t++) begin
            if (t == 3)  b_mask   = 12'h801;
            if (t == 15) b_mask   = '0;
            if (t == 24) b_repeat = 1'b0;
            if (b_valid) begin
                stream = {stream[34:0], b_data};
                nv++;
                if (t < 36) v36++;
            end
            if (t == 12) ec2 = b_err_cnt;
            if (t == 36) cnt_done = b_frame_cnt;
            if (b_done) begin
                if (done_at < 0) done_at = t;
                nd++;
            end
            step();
        end
        checks++;
        if (v36 != 36 || nv != 36) begin
            errors++; $display("FAIL repeat_valid got first36=%0d total=%0d want 36 36", v36, nv);
        end
        checks++;
        if (done_at != 36 || nd != 1) begin
            errors++; $display("FAIL repeat_done got at=%0d count=%0d want 36 1", done_at, nd);
        end
        checks++;
        if (stream[35:24] !== PAT || stream[23:12] !== ERR801 || stream[11:0] !== PAT) begin
            errors++; $display("FAIL repeat_frames got %h want %h%h%h", stream, PAT, ERR801, PAT);
        end
        checks++;
        if (ec2 !== 4'd2) begin
            errors++; $display("FAIL repeat_relatch_cnt got %0d want 2", ec2);
        end
        checks++;
        if (cnt_done !== 8'd3) begin
            errors++; $display("FAIL repeat_frames_cnt got %0d want 3", cnt_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] bits; int nv, ng, nd; logic [3:0] ec;
        a_mask  = 12'h801;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int t = 0; t < 6; t++) step();
        checks++;
        if (a_valid !== 1'b1 || a_busy !== 1'b1) begin
            errors++; $display("FAIL mid_frame_active got v=%b b=%b want 1 1", a_valid, a_busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({a_data, a_valid, a_busy, a_done} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_flags got %b want 0000", {a_data, a_valid, a_busy, a_done});
        end
        checks++;
        if (a_err_cnt !== 4'd0 || a_frame_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_reset_counts got err=%0d frames=%0d want 0 0", a_err_cnt, a_frame_cnt);
        end
        #1;
        resetn = 1'b1;
        capture_a(12'h000, bits, nv, ng, nd, ec);
        checks++;
        if (bits !== PAT || nv != 12 || ec !== 4'd0) begin
            errors++; $display("FAIL post_reset_frame got %b valid=%0d err=%0d want %b 12 0", bits, nv, ec, PAT);
        end
        checks++;
        if (a_frame_cnt !== 8'd1 || nd != 1) begin
            errors++; $display("FAIL post_reset_count got frames=%0d done=%0d want 1 1", a_frame_cnt, nd);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_err_inject();
        test_over_tolerance();
        test_busy_ignore();
        test_repeat();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
